// File: rtl/qmult_pipe.sv
// qmult_pipe: three-stage pipelined signed fixed-point multiplier.
// The operands are Q(WIDTH-FRAC).FRAC. Each operation carries its own rounding
// mode and saturation mode. A valid/ready handshake is used on both sides.
// The block also has an overflow flag and a sticky overflow status.
`timescale 1ns/1ps
module qmult_pipe #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    input  logic                    rnd_mode,
    input  logic                    sat_en,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] result,
    output logic                    ovf,
    output logic                    ovf_sticky,
    input  logic                    clr_sticky
);

    localparam int PW = 2 * WIDTH;      // full product width
    localparam int QW = 2 * WIDTH + 1;  // headroom for the rounding add

    // Add the rounding constant (half an LSB, or zero) to the product.
    // Then shift right arithmetically by FRAC. Ties round toward +inf.
    function automatic logic signed [QW-1:0] f_round(
        input logic signed [PW-1:0] p,
        input logic                 rnd
    );
        logic signed [QW-1:0] w_r;
        logic signed [QW-1:0] w_sum;
        w_r = '0;
        if (rnd)
            w_r[FRAC-1] = 1'b1;
        w_sum = $signed({p[PW-1], p}) + w_r;
        return w_sum >>> FRAC;
    endfunction

    // The value fits in WIDTH bits only when every bit from the sign position upward is equal.
    function automatic logic f_ovf(input logic signed [QW-1:0] q);
        return !((&q[QW-1:WIDTH-1]) | ~(|q[QW-1:WIDTH-1]));
    endfunction

    // On overflow, clamp to the extreme of the correct sign, or keep the low WIDTH bits.
    function automatic logic signed [WIDTH-1:0] f_sat(
        input logic signed [QW-1:0] q,
        input logic                 sat
    );
        logic signed [WIDTH-1:0] w_res;
        w_res = q[WIDTH-1:0];
        if (sat && f_ovf(q))
            w_res = q[QW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        return w_res;
    endfunction

    logic                    w_en;
    logic                    r_vld_p0, r_vld_p1, r_vld_p2;
    logic signed [WIDTH-1:0] r_a_p0, r_b_p0;
    logic                    r_rnd_p0, r_sat_p0, r_rnd_p1, r_sat_p1;
    logic signed [PW-1:0]    r_prod_p1;
    logic signed [PW-1:0]    w_prod;
    logic signed [QW-1:0]    w_q;
    logic signed [WIDTH-1:0] r_result_p2;
    logic                    r_ovf_p2;
    logic                    r_sticky;

    // All stages move together. The pipeline stalls only when the output is held.
    assign w_en      = ~r_vld_p2 | out_ready;
    assign in_ready  = w_en;
    assign out_valid = r_vld_p2;
    assign result    = r_result_p2;
    assign ovf       = r_ovf_p2;
    assign ovf_sticky = r_sticky;

    assign w_prod = $signed({{WIDTH{r_a_p0[WIDTH-1]}}, r_a_p0}) *
                    $signed({{WIDTH{r_b_p0[WIDTH-1]}}, r_b_p0});
    assign w_q    = f_round(r_prod_p1, r_rnd_p1);

    // Valid bits: a reset drops every in-flight transaction at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p0 <= 1'b0;
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
        end else if (w_en) begin
            r_vld_p0 <= in_valid;
            r_vld_p1 <= r_vld_p0;
            r_vld_p2 <= r_vld_p1;
        end
    end

    // ---- stage 0 -> 1: capture operands and modes, then form the full product
    // Operand and product datapath registers (no reset needed).
    always_ff @(posedge clk) begin
        if (w_en) begin
            r_a_p0    <= a;
            r_b_p0    <= b;
            r_rnd_p0  <= rnd_mode;
            r_sat_p0  <= sat_en;
            r_prod_p1 <= w_prod;
            r_rnd_p1  <= r_rnd_p0;
            r_sat_p1  <= r_sat_p0;
        end
    end

    // ---- stage 1 -> 2: round, check range, saturate or wrap
    // Output registers load only for real transactions, so bubbles leave them unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result_p2 <= '0;
            r_ovf_p2    <= 1'b0;
        end else if (w_en && r_vld_p1) begin
            r_result_p2 <= f_sat(w_q, r_sat_p1);
            r_ovf_p2    <= f_ovf(w_q);
        end
    end

    // Sticky overflow: an overflowing output transfer sets it and wins over a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_sticky <= 1'b0;
        else if (r_vld_p2 && out_ready && r_ovf_p2)
            r_sticky <= 1'b1;
        else if (clr_sticky)
            r_sticky <= 1'b0;
    end

endmodule
